// File: rtl/spi_apb_arbiter_pkg.sv
// Shared definitions for the SPI/debug APB arbiter: target selects, FSM states, helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_apb_arbiter_pkg;

  // psel encodings of the secure-gate APB port
  localparam logic [1:0] SEL_RM  = 2'b01;  // register map
  localparam logic [1:0] SEL_ICN = 2'b10;  // interconnect

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  // Only the two one-hot target selects produce an APB cycle.
  function automatic logic sel_legal(input logic [1:0] sel);
    return (sel == SEL_RM) || (sel == SEL_ICN);
  endfunction

endpackage

// File: rtl/spi_apb_arbiter_if.sv
// Bundle of the two-requester request/response channel and the APB master port.
// Latency: n/a (wiring only).
// Backpressure: req_ready one-hot accept on the request side; APB pready on the bus side.
// Modports: master = arbiter side (accepts requests, drives APB), slave = requesters + APB target.
interface spi_apb_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  localparam int STRB_W = DATA_W / 8;

  // request side, requester i occupies slice i of each packed vector
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [3:0]          req_sel;
  logic [1:0]          req_write;
  logic [2*STRB_W-1:0] req_strb;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  // response side
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  // APB port to the secure gate
  logic [1:0]          psel;
  logic                penable;
  logic                pwrite;
  logic [STRB_W-1:0]   pstrb;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr_rm;
  logic                pslverr_icn;
  logic                timeout_o;

  modport master (
    input  req_valid, req_sel, req_write, req_strb, req_addr, req_wdata,
    input  prdata, pready, pslverr_rm, pslverr_icn,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, pstrb, paddr, pwdata, timeout_o
  );

  modport slave (
    output req_valid, req_sel, req_write, req_strb, req_addr, req_wdata,
    output prdata, pready, pslverr_rm, pslverr_icn,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, pstrb, paddr, pwdata, timeout_o
  );

endinterface

// File: rtl/spi_apb_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the requester that did not win last.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own idle condition.
// Ports: valid[1:0] requests, last = index of previous winner, grant[1:0] one-hot (or zero).
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/spi_apb_arbiter.sv
// Shares the secure-gate APB port between the SPI command engine (req 0) and debug/DMA (req 1).
// Latency: accept T -> SETUP T+1 -> ACCESS T+2.. -> rsp_valid one cycle after pready; bad sel answers at T+1.
// Backpressure: one transfer in flight; req_ready only in IDLE; watchdog aborts after TIMEOUT ACCESS cycles.
// Ports: clk, reset_n (async, active-low), bus = request/response channel + APB master (see interface).
module spi_apb_arbiter
  import spi_apb_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_apb_arbiter_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;  // holds 0..TIMEOUT-1

  arb_state_t        state;
  logic              last_grant;
  logic              owner;
  logic [WD_W-1:0]   wdog;

  logic [1:0]        grant;
  logic              win;
  logic [1:0]        win_sel;
  logic              win_write;
  logic [STRB_W-1:0] win_strb;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        owner_oh;

  rr_arb2 u_rr_arb2 (
    .valid (bus.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Accept is offered only while idle so a waiting requester is never lost mid-transfer.
  assign bus.req_ready = (state == ST_IDLE) ? grant : 2'b00;

  assign win       = grant[1];
  assign win_sel   = win ? bus.req_sel[3:2]                  : bus.req_sel[1:0];
  assign win_write = win ? bus.req_write[1]                  : bus.req_write[0];
  assign win_strb  = win ? bus.req_strb[2*STRB_W-1:STRB_W]   : bus.req_strb[STRB_W-1:0];
  assign win_addr  = win ? bus.req_addr[2*ADDR_W-1:ADDR_W]   : bus.req_addr[ADDR_W-1:0];
  assign win_wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W]  : bus.req_wdata[DATA_W-1:0];
  assign owner_oh  = owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      wdog          <= '0;
      bus.psel      <= '0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.pstrb     <= '0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner      <= win;
            last_grant <= win;
            if (sel_legal(win_sel)) begin
              // APB output registers double as the latched request fields.
              state      <= ST_SETUP;
              bus.psel   <= win_sel;
              bus.pwrite <= win_write;
              bus.pstrb  <= win_strb;
              bus.paddr  <= win_addr;
              bus.pwdata <= win_wdata;
            end else begin
              // No target to address: answer straight away with an error.
              state         <= ST_RESP;
              bus.rsp_valid <= grant;
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state       <= ST_ACCESS;
          bus.penable <= 1'b1;
        end
        ST_ACCESS: begin
          // pready is checked first so a completion in the last allowed cycle beats the watchdog.
          if (bus.pready || (wdog == WD_W'(TIMEOUT - 1))) begin
            state         <= ST_RESP;
            bus.rsp_valid <= owner_oh;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.pstrb     <= '0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            if (bus.pready) begin
              bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
              bus.rsp_err   <= bus.pslverr_rm | bus.pslverr_icn;
            end else begin
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= 1'b1;
              bus.timeout_o <= 1'b1;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.rsp_valid <= '0;
          bus.timeout_o <= 1'b0;
          wdog          <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: directed cases with literal expectations, then random traffic.
// Model predicts each transfer's whole timeline at accept time from the latency rules.
// The APB target replies according to a per-request plan (wait count, data, error bits).
`timescale 1ns/1ps
module tb_spi_apb_arbiter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_apb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // per-requester reply plan, fixed while the request is pending
  int          plan_wait [2];
  logic [15:0] plan_rd   [2];
  logic        plan_erm  [2];
  logic        plan_eicn [2];

  // transaction model
  logic        last_g = 1'b1;
  logic        act = 1'b0;
  int          t_acc = 0, t_rsp = 0, m_wait = 0;
  logic        m_own = 1'b0, m_legal = 1'b0, m_to = 1'b0, m_err = 1'b0, m_wr = 1'b0;
  logic        m_erm = 1'b0, m_eicn = 1'b0;
  logic [1:0]  m_sel = '0, m_strb = '0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_rd = '0, m_prd = '0;
  logic [1:0]  acc_seen = '0;
  int          grant_q[$];

  // compare process: mid-cycle, all inputs and registered outputs are stable
  always @(negedge clk) begin : cmp
    logic [1:0] vld, e_rdy, e_psel, e_rv, acc;
    logic e_pen, e_to, inw;
    cyc++;
    vld = bus.req_valid;
    if (!reset_n) begin
      act = 1'b0;
      last_g = 1'b1;
      acc_seen = '0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_psel", bus.psel, 0);
      chk("rst_penable", bus.penable, 0);
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_pwdata", bus.pwdata, 0);
      chk("rst_pwrite", bus.pwrite, 0);
      chk("rst_pstrb", bus.pstrb, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_timeout", bus.timeout_o, 0);
    end else begin
      inw = act && cyc > t_acc && cyc < t_rsp;
      e_psel = inw ? m_sel : 2'b00;
      e_pen = inw && cyc >= t_acc + 2;
      e_rv = (act && cyc == t_rsp) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      e_to = act && cyc == t_rsp && m_to;
      chk("psel", bus.psel, e_psel);
      chk("penable", bus.penable, e_pen);
      chk("pwrite", bus.pwrite, inw ? m_wr : 1'b0);
      chk("pstrb", bus.pstrb, inw ? m_strb : 2'b00);
      chk("paddr", bus.paddr, inw ? m_addr : 20'h0);
      chk("pwdata", bus.pwdata, inw ? m_wdata : 16'h0);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("timeout_o", bus.timeout_o, e_to);
      if (e_rv != 2'b00) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rd);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (act && cyc <= t_rsp) e_rdy = 2'b00;
      else if (vld == 2'b11) e_rdy = last_g ? 2'b01 : 2'b10;
      else e_rdy = vld;
      chk("req_ready", bus.req_ready, e_rdy);
      acc = vld & e_rdy;
      acc_seen = acc;
      if (acc != 2'b00) begin
        m_own = acc[1];
        last_g = m_own;
        act = 1'b1;
        t_acc = cyc;
        grant_q.push_back(int'(m_own));
        m_sel   = m_own ? bus.req_sel[3:2]     : bus.req_sel[1:0];
        m_wr    = m_own ? bus.req_write[1]     : bus.req_write[0];
        m_strb  = m_own ? bus.req_strb[3:2]    : bus.req_strb[1:0];
        m_addr  = m_own ? bus.req_addr[39:20]  : bus.req_addr[19:0];
        m_wdata = m_own ? bus.req_wdata[31:16] : bus.req_wdata[15:0];
        m_wait  = plan_wait[m_own];
        m_prd   = plan_rd[m_own];
        m_erm   = plan_erm[m_own];
        m_eicn  = plan_eicn[m_own];
        m_legal = (m_sel == 2'b01) || (m_sel == 2'b10);
        m_to = 1'b0;
        if (!m_legal) begin
          t_rsp = cyc + 1; m_err = 1'b1; m_rd = '0;
        end else if (m_wait >= TIMEOUT) begin
          t_rsp = cyc + 2 + TIMEOUT; m_to = 1'b1; m_err = 1'b1; m_rd = '0;
        end else begin
          t_rsp = cyc + 3 + m_wait; m_err = m_erm | m_eicn; m_rd = m_wr ? 16'h0 : m_prd;
        end
      end
    end
  end

  // APB target: quiet during the transfer except on its planned completion cycle, noise elsewhere
  always @(posedge clk) begin : apb_tgt
    int nxt;
    logic inw, hit;
    #1;
    nxt = cyc + 1;
    inw = act && m_legal && nxt > t_acc && nxt < t_rsp;
    hit = inw && !m_to && nxt == t_acc + 2 + m_wait;
    bus.pready      = hit ? 1'b1 : (inw ? 1'b0 : 1'($urandom));
    bus.prdata      = hit ? m_prd : 16'($urandom);
    bus.pslverr_rm  = hit ? m_erm : 1'($urandom);
    bus.pslverr_icn = hit ? m_eicn : 1'($urandom);
  end

  logic [1:0] last_acc = '0;

  // advance one cycle; requesters drop valid once accepted
  task automatic step();
    @(posedge clk);
    #2;
    last_acc = acc_seen;
    for (int i = 0; i < 2; i++) if (acc_seen[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic launch(input int i, input logic [1:0] sel, input logic wr, input logic [1:0] strb,
                        input logic [19:0] addr, input logic [15:0] wdata, input int w,
                        input logic [15:0] rd, input logic erm, input logic eicn);
    bus.req_sel[2*i +: 2]    = sel;
    bus.req_write[i]         = wr;
    bus.req_strb[2*i +: 2]   = strb;
    bus.req_addr[20*i +: 20] = addr;
    bus.req_wdata[16*i +: 16] = wdata;
    plan_wait[i] = w;
    plan_rd[i]   = rd;
    plan_erm[i]  = erm;
    plan_eicn[i] = eicn;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic launch_rand(input int i, input bit legal_only);
    int r, rw, w;
    logic [1:0] sel;
    r = $urandom_range(0, 9);
    if (!legal_only && r == 0) sel = 2'b00;
    else if (!legal_only && r == 1) sel = 2'b11;
    else sel = r[0] ? 2'b01 : 2'b10;
    rw = $urandom_range(0, 19);
    if (!legal_only && rw == 0) w = TIMEOUT - 1;
    else if (!legal_only && rw == 1) w = TIMEOUT + $urandom_range(0, 20);
    else w = $urandom_range(0, 3);
    launch(i, sel, 1'($urandom), 2'($urandom), 20'($urandom), 16'($urandom), w, 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 600; k++) begin
      if (bus.req_valid == 2'b00 && !(act && cyc + 1 <= t_rsp)) return;
      step();
    end
    fail_now("drain");
  endtask

  // one request from an idle bus; response expected exactly lat cycles after accept
  task automatic run_one(input string nm, input int i, input logic [1:0] sel, input logic wr,
                         input int w, input logic [15:0] rd, input logic erm, input logic eicn,
                         input int lat, input logic [1:0] e_rv, input logic e_err,
                         input logic [15:0] e_rd, input logic e_to);
    int t;
    step();
    launch(i, sel, wr, 2'b11, 20'($urandom), 16'($urandom), w, rd, erm, eicn);
    t = -1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      step();
      if (last_acc[i]) t = cyc;
    end
    if (t < 0) begin
      fail_now({nm, "_accept"});
      return;
    end
    while (cyc + 1 < t + lat) step();
    chk({nm, "_rsp_valid"}, bus.rsp_valid, e_rv);
    chk({nm, "_rsp_err"}, bus.rsp_err, e_err);
    chk({nm, "_rsp_rdata"}, bus.rsp_rdata, e_rd);
    chk({nm, "_timeout"}, bus.timeout_o, e_to);
    step();
    chk({nm, "_after_psel"}, bus.psel, 2'b00);
    chk({nm, "_after_rsp"}, bus.rsp_valid, 2'b00);
  endtask

  initial begin : main
    int t0, t, nrsp;
    bus.req_valid = '0; bus.req_sel = '0; bus.req_write = '0;
    bus.req_strb = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) step();
    chk("reset_psel", bus.psel, 2'b00);
    chk("reset_rsp_valid", bus.rsp_valid, 2'b00);
    reset_n = 1'b1;
    step();
    chk("post_reset_penable", bus.penable, 1'b0);
    chk("post_reset_timeout", bus.timeout_o, 1'b0);

    // simultaneous first pair: requester 0 wins because last_grant starts at 1
    launch(0, 2'b01, 1'b0, 2'b11, 20'h00010, 16'h0, 0, 16'h1234, 1'b0, 1'b0);
    launch(1, 2'b10, 1'b0, 2'b11, 20'h00200, 16'h0, 0, 16'h5678, 1'b0, 1'b0);
    #1;
    chk("pair_first_grant", bus.req_ready, 2'b01);
    t0 = cyc + 1;
    step();
    chk("rd_setup_psel", bus.psel, 2'b01);
    chk("rd_setup_penable", bus.penable, 1'b0);
    chk("rd_setup_paddr", bus.paddr, 20'h00010);
    step();
    chk("rd_access_penable", bus.penable, 1'b1);
    chk("rd_access_psel", bus.psel, 2'b01);
    step();
    chk("rd_rsp_valid", bus.rsp_valid, 2'b01);
    chk("rd_rsp_rdata", bus.rsp_rdata, 16'h1234);
    chk("rd_rsp_err", bus.rsp_err, 1'b0);
    chk("rd_rsp_cycle", cyc + 1, t0 + 3);
    step();
    #1;
    chk("pair_second_grant", bus.req_ready, 2'b10);

    // both requesters kept busy: grants must alternate
    for (int k = 0; k < 30; k++) begin
      step();
      for (int i = 0; i < 2; i++) if (!bus.req_valid[i]) launch_rand(i, 1'b1);
    end
    drain();
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_grant%0d", k), (grant_q.size() > k) ? grant_q[k] : 99, k % 2);

    run_one("icn_wr_err", 1, 2'b10, 1'b1, 1, 16'hDEAD, 1'b0, 1'b1, 4, 2'b10, 1'b1, 16'h0, 1'b0);
    run_one("wdog", 0, 2'b01, 1'b0, 500, 16'h1111, 1'b0, 1'b0, 66, 2'b01, 1'b1, 16'h0, 1'b1);
    run_one("after_wdog", 1, 2'b01, 1'b0, 0, 16'hBEEF, 1'b0, 1'b0, 3, 2'b10, 1'b0, 16'hBEEF, 1'b0);
    run_one("last_cycle_rdy", 0, 2'b10, 1'b0, 63, 16'hA5A5, 1'b0, 1'b0, 66, 2'b01, 1'b0, 16'hA5A5, 1'b0);
    run_one("rm_wr_err", 0, 2'b01, 1'b1, 2, 16'h7777, 1'b1, 1'b0, 5, 2'b01, 1'b1, 16'h0, 1'b0);
    run_one("illegal11", 1, 2'b11, 1'b0, 0, 16'h4321, 1'b0, 1'b0, 1, 2'b10, 1'b1, 16'h0, 1'b0);
    run_one("illegal00", 0, 2'b00, 1'b1, 0, 16'h4321, 1'b0, 1'b0, 1, 2'b01, 1'b1, 16'h0, 1'b0);

    // reset pulsed in the middle of ACCESS: transfer vanishes, no response
    step();
    launch(0, 2'b01, 1'b0, 2'b01, 20'h0ABCD, 16'h0, 30, 16'h9999, 1'b0, 1'b0);
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      step();
      if (last_acc[0]) t = cyc;
    end
    if (t < 0) fail_now("midrst_accept");
    while (t >= 0 && cyc + 1 < t + 6) step();
    chk("midrst_in_access", bus.penable, 1'b1);
    reset_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("midrst_psel", bus.psel, 2'b00);
    chk("midrst_penable", bus.penable, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.rsp_valid != 2'b00) nrsp++;
    end
    chk("midrst_no_rsp", nrsp, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) launch_rand(i, 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
